// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: pulses PLL reset, waits for a stable synchronised LOCK with
// timeout/retry, then releases the downstream system reset; re-sequences on lock loss or request.
module pll_lock_sequencer #(
   parameter int RST_HOLD_CYCLES    = 16,
   parameter int LOCK_TIMEOUT       = 5000,
   parameter int LOCK_STABLE_CYCLES = 256,
   parameter int MAX_RETRY          = 7,
   parameter int SYNC_STAGES        = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_lock_i,
   input  logic       force_relock_i,
   output logic       pll_reset_o,
   output logic       sys_rst_n_o,
   output logic       ready_o,
   output logic       fail_o,
   output logic [3:0] retry_cnt_o,
   output logic [2:0] state_o
);

   localparam int HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
   localparam int TMO_W  = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
   localparam int STAB_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
   localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [4:0]        RETRY_MAX = 5'(MAX_RETRY);

   typedef enum logic [2:0] {
      ST_HOLD   = 3'd0,
      ST_WAIT   = 3'd1,
      ST_STABLE = 3'd2,
      ST_RUN    = 3'd3,
      ST_FAIL   = 3'd4
   } state_t;

   state_t                   state_q, state_d;
   logic [HOLD_W-1:0]        hold_cnt_q, hold_cnt_d;
   logic [TMO_W-1:0]         tmo_cnt_q, tmo_cnt_d;
   logic [STAB_W-1:0]        stab_cnt_q, stab_cnt_d;
   logic [3:0]               retry_q, retry_d;
   logic [SYNC_STAGES-1:0]   sync_q, sync_d;
   logic                     pll_reset_q, pll_reset_d;
   logic                     sys_rst_n_q, sys_rst_n_d;
   logic                     ready_q, ready_d;
   logic                     fail_q, fail_d;
   logic [4:0]               retry_inc;
   logic                     lock_s;

   assign lock_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], pll_lock_i};
   end

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      stab_cnt_d = stab_cnt_q;
      retry_d    = retry_q;
      retry_inc  = {1'b0, retry_q} + 5'd1;

      if (force_relock_i) begin
         state_d    = ST_HOLD;
         hold_cnt_d = '0;
         tmo_cnt_d  = '0;
         stab_cnt_d = '0;
         retry_d    = 4'd0;
      end else begin
         unique case (state_q)
            ST_HOLD: begin
               tmo_cnt_d  = '0;
               stab_cnt_d = '0;
               if (hold_cnt_q == HOLD_LAST) begin
                  state_d    = ST_WAIT;
                  hold_cnt_d = '0;
               end else begin
                  hold_cnt_d = hold_cnt_q + 1'b1;
               end
            end
            ST_WAIT, ST_STABLE: begin
               // The timeout window spans WAIT and STABLE together and beats promotion to RUN.
               if (tmo_cnt_q == TMO_LAST) begin
                  retry_d    = (retry_q == 4'hF) ? 4'hF : retry_inc[3:0];
                  state_d    = (retry_inc > RETRY_MAX) ? ST_FAIL : ST_HOLD;
                  hold_cnt_d = '0;
                  tmo_cnt_d  = '0;
                  stab_cnt_d = '0;
               end else begin
                  tmo_cnt_d = tmo_cnt_q + 1'b1;
                  if (state_q == ST_WAIT) begin
                     if (lock_s) begin
                        state_d    = ST_STABLE;
                        stab_cnt_d = '0;
                     end
                  end else if (!lock_s) begin
                     state_d    = ST_WAIT;
                     stab_cnt_d = '0;
                  end else if (stab_cnt_q == STAB_LAST) begin
                     state_d    = ST_RUN;
                     stab_cnt_d = '0;
                     retry_d    = 4'd0;
                  end else begin
                     stab_cnt_d = stab_cnt_q + 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (!lock_s) begin
                  state_d    = ST_HOLD;
                  hold_cnt_d = '0;
                  tmo_cnt_d  = '0;
                  stab_cnt_d = '0;
               end
            end
            ST_FAIL: begin
               state_d = ST_FAIL;
            end
            default: begin
               state_d    = ST_HOLD;
               hold_cnt_d = '0;
               tmo_cnt_d  = '0;
               stab_cnt_d = '0;
            end
         endcase
      end

      // Outputs are decoded from the next state so they flip on the same edge as the state.
      pll_reset_d = (state_d == ST_HOLD) || (state_d == ST_FAIL);
      sys_rst_n_d = (state_d == ST_RUN);
      ready_d     = (state_d == ST_RUN);
      fail_d      = (state_d == ST_FAIL);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_HOLD;
         hold_cnt_q  <= '0;
         tmo_cnt_q   <= '0;
         stab_cnt_q  <= '0;
         retry_q     <= 4'd0;
         sync_q      <= '0;
         pll_reset_q <= 1'b1;
         sys_rst_n_q <= 1'b0;
         ready_q     <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         stab_cnt_q  <= stab_cnt_d;
         retry_q     <= retry_d;
         sync_q      <= sync_d;
         pll_reset_q <= pll_reset_d;
         sys_rst_n_q <= sys_rst_n_d;
         ready_q     <= ready_d;
         fail_q      <= fail_d;
      end
   end

   assign pll_reset_o = pll_reset_q;
   assign sys_rst_n_o = sys_rst_n_q;
   assign ready_o     = ready_q;
   assign fail_o      = fail_q;
   assign retry_cnt_o = retry_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed scenarios plus randomized lock/relock
// traffic, all compared every cycle against a behavioural reference model of the sequencing rules.
module tb_pll_lock_sequencer;

   localparam int RST_HOLD  = 4;
   localparam int TMO       = 40;
   localparam int STAB      = 8;
   localparam int MAX_RETRY = 2;
   localparam int SYNC      = 2;

   localparam int M_HOLD    = 0;
   localparam int M_LOCKING = 1;
   localparam int M_RUN     = 2;
   localparam int M_FAIL    = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pllLock = 1'b0;
   logic       forceRelock = 1'b0;
   logic       pllReset;
   logic       sysRstN;
   logic       ready;
   logic       fail;
   logic [3:0] retryCnt;
   logic [2:0] stateDbg;

   int compared = 0;
   int mismatched = 0;

   // Reference model: one phase for the whole WAIT/STABLE lock hunt, with a streak of
   // consecutive synchronised lock samples and the elapsed time since the PLL reset released.
   int mPhase;
   int mHoldAge;
   int mElapsed;
   int mStreak;
   int mRetries;
   bit mSyncQ[$];

   pll_lock_sequencer #(
      .RST_HOLD_CYCLES(RST_HOLD),
      .LOCK_TIMEOUT(TMO),
      .LOCK_STABLE_CYCLES(STAB),
      .MAX_RETRY(MAX_RETRY),
      .SYNC_STAGES(SYNC)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .pll_lock_i(pllLock),
      .force_relock_i(forceRelock),
      .pll_reset_o(pllReset),
      .sys_rst_n_o(sysRstN),
      .ready_o(ready),
      .fail_o(fail),
      .retry_cnt_o(retryCnt),
      .state_o(stateDbg)
   );

   // Free-running 10-time-unit reference clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0d, expected %0d at time %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      mPhase   = M_HOLD;
      mHoldAge = 0;
      mElapsed = 0;
      mStreak  = 0;
      mRetries = 0;
      mSyncQ   = {};
      for (int i = 0; i < SYNC; i++) mSyncQ.push_back(1'b0);
   endtask

   // The FSM sees the raw lock as it was SYNC edges earlier.
   task automatic modelStep(input bit rawLock, input bit forceIn);
      bit lockSeen;
      int newRetries;
      lockSeen = mSyncQ.pop_front();
      mSyncQ.push_back(rawLock);
      if (forceIn) begin
         mPhase   = M_HOLD;
         mHoldAge = 0;
         mRetries = 0;
      end else begin
         case (mPhase)
            M_HOLD: begin
               mHoldAge++;
               if (mHoldAge == RST_HOLD) begin
                  mPhase   = M_LOCKING;
                  mElapsed = 0;
                  mStreak  = 0;
               end
            end
            M_LOCKING: begin
               if (mElapsed == TMO - 1) begin
                  newRetries = mRetries + 1;
                  mRetries   = (newRetries > 15) ? 15 : newRetries;
                  mPhase     = (newRetries > MAX_RETRY) ? M_FAIL : M_HOLD;
                  mHoldAge   = 0;
               end else begin
                  mElapsed++;
                  mStreak = lockSeen ? mStreak + 1 : 0;
                  // One sample ends the wait, then STAB more consecutive samples qualify it.
                  if (mStreak == STAB + 1) begin
                     mPhase   = M_RUN;
                     mRetries = 0;
                  end
               end
            end
            M_RUN: begin
               if (!lockSeen) begin
                  mPhase   = M_HOLD;
                  mHoldAge = 0;
               end
            end
            default: ;
         endcase
      end
   endtask

   task automatic checkAll();
      int expState;
      case (mPhase)
         M_HOLD:    expState = 0;
         M_LOCKING: expState = (mStreak > 0) ? 2 : 1;
         M_RUN:     expState = 3;
         default:   expState = 4;
      endcase
      checkOutput("state_o", 32'(stateDbg), 32'(expState));
      checkOutput("pll_reset_o", 32'(pllReset), 32'((mPhase == M_HOLD) || (mPhase == M_FAIL)));
      checkOutput("sys_rst_n_o", 32'(sysRstN), 32'(mPhase == M_RUN));
      checkOutput("ready_o", 32'(ready), 32'(mPhase == M_RUN));
      checkOutput("fail_o", 32'(fail), 32'(mPhase == M_FAIL));
      checkOutput("retry_cnt_o", 32'(retryCnt), 32'(mRetries));
   endtask

   // Drives the inputs for a number of cycles, stepping the model at each rising edge and
   // comparing every output on the following falling edge.
   task automatic applyStimulus(input bit lockIn, input bit forceIn, input int cycles);
      for (int c = 0; c < cycles; c++) begin
         pllLock     = lockIn;
         forceRelock = forceIn;
         @(posedge clk);
         modelStep(pllLock, forceRelock);
         @(negedge clk);
         checkAll();
      end
   endtask

   // Main sequence: directed scenarios first, then randomized lock behaviour.
   initial begin
      int lat;
      int runLeft;
      bit lockLvl;

      modelReset();
      repeat (2) @(negedge clk);
      checkAll();
      rst_n = 1'b1;

      // Bring-up: reset pulse length, then lock-to-ready latency.
      applyStimulus(1'b0, 1'b0, 3);
      checkOutput("holdStillHigh", 32'(pllReset), 32'd1);
      applyStimulus(1'b0, 1'b0, 1);
      checkOutput("holdReleased", 32'(pllReset), 32'd0);
      applyStimulus(1'b0, 1'b0, 9);
      lat = 0;
      while (!ready && lat < 30) begin
         applyStimulus(1'b1, 1'b0, 1);
         lat++;
      end
      checkOutput("lockToReadyInRange", 32'((lat >= 11) && (lat <= 12)), 32'd1);
      checkOutput("runState", 32'(stateDbg), 32'd3);
      checkOutput("runSysRst", 32'(sysRstN), 32'd1);

      // Lock loss in RUN, then re-lock.
      lat = 0;
      while (ready && lat < 10) begin
         applyStimulus(1'b0, 1'b0, 1);
         lat++;
      end
      checkOutput("lossToNotReady", 32'(lat <= SYNC + 1), 32'd1);
      checkOutput("lossRetryUnchanged", 32'(retryCnt), 32'd0);
      applyStimulus(1'b0, 1'b0, 4);
      applyStimulus(1'b1, 1'b0, 20);
      checkOutput("relockRun", 32'(stateDbg), 32'd3);

      // Lock never comes back: retries exhaust into FAIL.
      applyStimulus(1'b0, 1'b0, 200);
      checkOutput("failFlag", 32'(fail), 32'd1);
      checkOutput("failState", 32'(stateDbg), 32'd4);
      checkOutput("failRetries", 32'(retryCnt), 32'd3);
      checkOutput("failPllReset", 32'(pllReset), 32'd1);
      checkOutput("failSysRst", 32'(sysRstN), 32'd0);

      // Forced relock out of FAIL, then a one-cycle lock glitch during qualification.
      applyStimulus(1'b0, 1'b1, 1);
      checkOutput("forceState", 32'(stateDbg), 32'd0);
      checkOutput("forceRetry", 32'(retryCnt), 32'd0);
      checkOutput("forceFail", 32'(fail), 32'd0);
      applyStimulus(1'b0, 1'b0, 4);
      applyStimulus(1'b1, 1'b0, 5);
      checkOutput("glitchPreStable", 32'(stateDbg), 32'd2);
      applyStimulus(1'b0, 1'b0, 1);
      applyStimulus(1'b1, 1'b0, 20);
      checkOutput("glitchRecoveredRun", 32'(stateDbg), 32'd3);
      checkOutput("glitchNoRetry", 32'(retryCnt), 32'd0);

      // Timeout on the very edge that would otherwise promote to RUN must win.
      applyStimulus(1'b0, 1'b1, 1);
      applyStimulus(1'b0, 1'b0, 4 + 29);
      applyStimulus(1'b1, 1'b0, 11);
      checkOutput("tmoBeatsRunState", 32'(stateDbg), 32'd0);
      checkOutput("tmoBeatsRunRetry", 32'(retryCnt), 32'd1);
      applyStimulus(1'b0, 1'b1, 1);
      applyStimulus(1'b0, 1'b0, 4 + 28);
      applyStimulus(1'b1, 1'b0, 11);
      checkOutput("lastCycleRun", 32'(stateDbg), 32'd3);

      // Asynchronous reset in the middle of STABLE.
      applyStimulus(1'b1, 1'b1, 1);
      applyStimulus(1'b1, 1'b0, 4 + 5);
      checkOutput("preResetStable", 32'(stateDbg), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      modelReset();
      checkAll();
      checkOutput("asyncPllReset", 32'(pllReset), 32'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkAll();
      rst_n = 1'b1;

      // Randomized lock run lengths with occasional relock requests.
      lockLvl = 1'b0;
      runLeft = 0;
      for (int n = 0; n < 2500; n++) begin
         if (runLeft == 0) begin
            lockLvl = ~lockLvl;
            runLeft = lockLvl ? int'($urandom_range(1, 70)) : int'($urandom_range(1, 30));
         end
         runLeft--;
         applyStimulus(lockLvl, ($urandom_range(0, 199) == 0), 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
